// File: rtl/sc_fifo_if.sv
// Handshake and status bundle for sc_fifo: the producer/consumer side uses
// the master modport and the FIFO itself uses the slave modport.
interface sc_fifo_if #(
  parameter int lpm_width  = 8,
  parameter int lpm_widthu = 4
);
  logic                  wrreq;
  logic [lpm_width-1:0]  data;
  logic                  rdreq;
  logic [lpm_width-1:0]  q;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic [lpm_widthu-1:0] usedw;
  logic [1:0]            eccstatus;

  modport master (
    output wrreq, data, rdreq,
    input  q, full, almost_full, empty, almost_empty, usedw, eccstatus
  );

  modport slave (
    input  wrreq, data, rdreq,
    output q, full, almost_full, empty, almost_empty, usedw, eccstatus
  );
endinterface

// File: rtl/sc_fifo.sv
// Single-clock circular-buffer FIFO, behaviorally compatible with the vendor
// scfifo: show-ahead or registered output, occupancy count and threshold flags.
module sc_fifo #(
  parameter int    lpm_width               = 8,
  parameter int    lpm_numwords            = 16,
  parameter int    lpm_widthu              = 4,
  parameter string lpm_showahead           = "ON",
  parameter int    almost_full_value       = 0,
  parameter int    almost_empty_value      = 0,
  parameter string overflow_checking       = "ON",
  parameter string underflow_checking      = "ON",
  parameter string add_ram_output_register = "OFF",
  parameter string intended_device_family  = "Cyclone V",
  parameter string lpm_hint                = "",
  parameter string lpm_type                = "scfifo",
  parameter string use_eab                 = "ON"
) (
  input  logic     clock,
  input  logic     sclr,
  input  logic     aclr,
  sc_fifo_if.slave bus
);
  localparam bit show_ahead = (lpm_showahead == "ON");
  localparam bit ovf_check  = (overflow_checking == "ON");
  localparam bit udf_check  = (underflow_checking == "ON");
  localparam int cw         = lpm_widthu + 1;

  logic [lpm_width-1:0]  mem [lpm_numwords];
  logic [lpm_widthu-1:0] wr_ptr;
  logic [lpm_widthu-1:0] rd_ptr;
  logic [cw-1:0]         count;
  logic [lpm_width-1:0]  q_reg;
  logic [31:0]           count_ext;
  logic                  clr;
  logic                  is_full;
  logic                  is_empty;
  logic                  do_wr;
  logic                  do_rd;

  assign clr       = sclr | aclr;
  assign count_ext = 32'(count);
  assign is_full   = (count_ext == 32'(lpm_numwords));
  assign is_empty  = (count == '0);
  assign do_wr     = bus.wrreq & ~(is_full & ovf_check);
  assign do_rd     = bus.rdreq & ~(is_empty & udf_check);

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + lpm_widthu'(1);
      if (do_rd)
        rd_ptr <= rd_ptr + lpm_widthu'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (do_wr && !clr)
      mem[wr_ptr] <= bus.data;
  end

  always_ff @(posedge clock) begin
    if (do_rd && !clr)
      q_reg <= mem[rd_ptr];
  end

  assign bus.q            = show_ahead ? mem[rd_ptr] : q_reg;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_ext >= 32'(almost_full_value));
  assign bus.almost_empty = (count_ext < 32'(almost_empty_value));
  assign bus.usedw        = count[lpm_widthu-1:0];
  assign bus.eccstatus    = 2'b00;
endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: a show-ahead instance is checked on every phase,
// and a normal-mode twin fed the same requests is checked on its read data.
module tb_sc_fifo;
  logic clock;
  logic sclr;
  logic aclr;
  int   checkCount;
  int   passCount;

  sc_fifo_if #(.lpm_width(8), .lpm_widthu(4)) bus ();
  sc_fifo_if #(.lpm_width(8), .lpm_widthu(4)) bus_n ();

  assign bus_n.wrreq = bus.wrreq;
  assign bus_n.rdreq = bus.rdreq;
  assign bus_n.data  = bus.data;

  sc_fifo #(
    .lpm_width(8), .lpm_numwords(16), .lpm_widthu(4), .lpm_showahead("ON"),
    .almost_full_value(12), .almost_empty_value(2)
  ) u_sa (
    .clock(clock), .sclr(sclr), .aclr(aclr), .bus(bus)
  );

  sc_fifo #(
    .lpm_width(8), .lpm_numwords(16), .lpm_widthu(4), .lpm_showahead("OFF"),
    .almost_full_value(12), .almost_empty_value(2)
  ) u_norm (
    .clock(clock), .sclr(sclr), .aclr(aclr), .bus(bus_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle of requests, let the edge happen, then settle just after it.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d, input logic rst);
    bus.wrreq = wr;
    bus.rdreq = rd;
    bus.data  = d;
    sclr      = rst;
    @(posedge clock);
    #1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    sclr      = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [7:0] exp);
    checkOutput({tag, "_sa_q"}, 32'(bus.q), 32'(exp));
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput({tag, "_norm_q"}, 32'(bus_n.q), 32'(exp));
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    aclr       = 1'b0;
    sclr       = 1'b1;
    bus.wrreq  = 1'b0;
    bus.rdreq  = 1'b0;
    bus.data   = 8'h00;

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_usedw", 32'(bus.usedw), 32'd0);
    checkOutput("rst_afull", 32'(bus.almost_full), 32'd0);
    checkOutput("rst_aempty", 32'(bus.almost_empty), 32'd1);
    checkOutput("rst_ecc", 32'(bus.eccstatus), 32'd0);

    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0);
    checkOutput("sa_empty", 32'(bus.empty), 32'd0);
    checkOutput("sa_q", 32'(bus.q), 32'hA5);
    checkOutput("sa_usedw", 32'(bus.usedw), 32'd1);
    checkOutput("sa_aempty", 32'(bus.almost_empty), 32'd1);
    popCheck("sa_pop", 8'hA5);
    checkOutput("sa_empty_after", 32'(bus.empty), 32'd1);

    // Pointers now sit at 1, so the fill also exercises wrap-around.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
      checkOutput($sformatf("fill_afull_%0d", i), 32'(bus.almost_full), 32'(i + 1 >= 12));
      checkOutput($sformatf("fill_full_%0d", i), 32'(bus.full), 32'(i == 15));
      checkOutput($sformatf("fill_usedw_%0d", i), 32'(bus.usedw), 32'((i + 1) % 16));
    end

    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0);
    checkOutput("ovf_full", 32'(bus.full), 32'd1);
    checkOutput("ovf_usedw", 32'(bus.usedw), 32'd0);
    checkOutput("ovf_empty", 32'(bus.empty), 32'd0);

    checkOutput("ovfrw_q", 32'(bus.q), 32'h00);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0);
    checkOutput("ovfrw_full", 32'(bus.full), 32'd0);
    checkOutput("ovfrw_usedw", 32'(bus.usedw), 32'd15);
    checkOutput("ovfrw_norm_q", 32'(bus_n.q), 32'h00);

    for (int i = 1; i < 16; i++)
      popCheck($sformatf("drain_%0d", i), 8'(i));
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);
    checkOutput("drain_usedw", 32'(bus.usedw), 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("udf_usedw_%0d", i), 32'(bus.usedw), 32'd0);
      checkOutput($sformatf("udf_empty_%0d", i), 32'(bus.empty), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
    checkOutput("udf_wr_usedw", 32'(bus.usedw), 32'd1);
    popCheck("udf_pop", 8'h11);
    checkOutput("udf_empty_end", 32'(bus.empty), 32'd1);

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    checkOutput("sim_pre_usedw", 32'(bus.usedw), 32'd5);
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("sim_sa_q_%0d", k), 32'(bus.q), 32'(8'h20 + k));
      applyStimulus(1'b1, 1'b1, 8'(8'h25 + k), 1'b0);
      checkOutput($sformatf("sim_usedw_%0d", k), 32'(bus.usedw), 32'd5);
      checkOutput($sformatf("sim_norm_q_%0d", k), 32'(bus_n.q), 32'(8'h20 + k));
    end
    checkOutput("sim_head", 32'(bus.q), 32'h34);

    applyStimulus(1'b1, 1'b0, 8'h39, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h3A, 1'b0);
    checkOutput("mid_usedw", 32'(bus.usedw), 32'd7);
    checkOutput("mid_aempty", 32'(bus.almost_empty), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b1);
    checkOutput("mid_rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("mid_rst_usedw", 32'(bus.usedw), 32'd0);
    checkOutput("mid_rst_aempty", 32'(bus.almost_empty), 32'd1);
    checkOutput("mid_rst_full", 32'(bus.full), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
    checkOutput("post_rst_q", 32'(bus.q), 32'h5A);
    checkOutput("post_rst_usedw", 32'(bus.usedw), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/sc_fifo.md
# sc_fifo

Single-clock, parameterizable synchronous FIFO with optional show-ahead output, occupancy count and programmable almost-full/almost-empty thresholds. It is the storage primitive under the platform HAL FIFO wrappers, which wrap it with reset masking of `full`/`almost_full` and extend `usedw` by one bit using `full` as the MSB. It is a vendor-compatible behavioral model, so its parameter and port names match the vendor single-clock FIFO.

## Interface
- `lpm_width`, 8: data width in bits.
- `lpm_numwords`, 16: capacity in words. Power of two, equal to 2**`lpm_widthu`.
- `lpm_widthu`, 4: width of `usedw`.
- `lpm_showahead`, "ON": "ON" selects show-ahead output; "OFF" selects normal read mode.
- `almost_full_value`, 0: threshold for `almost_full`.
- `almost_empty_value`, 0: threshold for `almost_empty`.
- `overflow_checking`, "ON": when "ON", writes while full are ignored.
- `underflow_checking`, "ON": when "ON", reads while empty are ignored.
- `add_ram_output_register`, `intended_device_family`, `lpm_hint`, `lpm_type`, `use_eab`, string defaults: accepted for compatibility. They have no effect on cycle behavior.

Ports:
- `clock` in 1: the single clock; all state updates on its rising edge.
- `sclr` in 1: reset. One clock; reset is synchronous and active-high.
- `aclr` in 1: compatibility clear. It is ORed into `sclr` and sampled synchronously; normally tied 0.
- `wrreq` in 1: write request.
- `data` in `lpm_width`: write data.
- `rdreq` in 1: read request. In show-ahead mode it acknowledges (pops) the current `q`.
- `q` out `lpm_width`: read data.
- `full` out 1: high when count == `lpm_numwords`.
- `almost_full` out 1: high when count >= `almost_full_value`.
- `empty` out 1: high when count == 0.
- `almost_empty` out 1: high when count < `almost_empty_value`.
- `usedw` out `lpm_widthu`: count modulo 2**`lpm_widthu`; reads 0 when full.
- `eccstatus` out 2: always 2'b00.

## Operation
- **Storage:** circular buffer of `lpm_numwords` entries with write pointer, read pointer and a count register of `lpm_widthu`+1 bits. Pointers wrap modulo `lpm_numwords`.
- **Effective write:** `wrreq` and not (`full` and overflow checking ON). It stores `data` at the write pointer and advances the write pointer.
- **Effective read:** `rdreq` and not (`empty` and underflow checking ON). It advances the read pointer.
- **Count update:** +1 on write only, −1 on read only, unchanged on both or neither.
- **Simultaneous read and write:**
  - While full with overflow checking ON, the write is ignored and the read proceeds; the count drops by 1.
  - While empty with underflow checking ON, the read is ignored and the write proceeds; the count rises by 1.
  - Otherwise both take effect and the count is unchanged.
- **Checking OFF:** with overflow or underflow checking "OFF", an overflow or underflow request is a usage error. Pointers update regardless, and contents and flags are undefined until reset.
- **Show-ahead "ON":** `q` = mem[rd_ptr] combinationally whenever `empty`=0, so the head word is presented without a request. `q` is don't-care while `empty`=1.
- **Normal mode "OFF":** `q` is registered. It loads mem[rd_ptr] on the edge of an effective read and holds otherwise.
- **Flags:** `full`, `empty`, `almost_full`, `almost_empty` and `usedw` are all decoded from the count register, so they change only on clock edges.
- **Reset:** clears both pointers and the count. Memory contents are not cleared.

## Timing
- **Reset values** (cycle after an edge with `sclr`=1):
  - `empty`=1, `full`=0, `usedw`=0.
  - `almost_full` = (0 >= `almost_full_value`).
  - `almost_empty` = (0 < `almost_empty_value`).
  - `q` don't-care; `eccstatus`=0.
- **Reset priority:** `sclr` overrides `wrreq`/`rdreq` in the same cycle.
- **Write latency:** a write accepted at edge N makes `empty`=0, with the word on `q` in show-ahead mode, in the cycle after N (1-cycle latency).
- **Show-ahead read:** a read at edge N presents the next word, or asserts `empty`, in the cycle after N.
- **Normal-mode read:** data appears on `q` in the cycle after the read edge.
- **Flag timing:** `full` asserts in the cycle after the write that makes count == `lpm_numwords`; `usedw` reads 0 at that point.
- **Reset mid-operation:** stored data is discarded and the FIFO appears empty in the next cycle.

## Test plan
- **Fill/drain order:** width 8, depth 16. Reset, then write 0x00..0x0F on consecutive cycles. Expect `full`=1 and `usedw`=0 after the 16th write; `almost_full` (value 12) high from count 12. Pop 16 words and check `q` = 0x00..0x0F in order, then `empty`=1.
- **Show-ahead latency:** write 0xA5 to the empty FIFO at edge N. Expect `empty`=0 and `q`=0xA5 in the cycle after N with no `rdreq`. Pop and expect `empty`=1 in the next cycle.
- **Overflow protection:** with the FIFO full and checking ON, assert `wrreq`=1, `data`=0xFF. Expect the count unchanged and no 0xFF in the drained data. Then assert `wrreq`+`rdreq` while full: expect count 15 and the write ignored.
- **Underflow protection:** with the FIFO empty and checking ON, assert `rdreq` for 3 cycles. Expect `usedw`=0 and `empty`=1. A later write of 0x11 reads back as 0x11.
- **Simultaneous traffic:** at count 5, assert `wrreq`+`rdreq` for 20 cycles. Expect `usedw`=5 throughout, order preserved, and pointers wrapping correctly.
- **Reset mid-stream:** at count 7, assert `sclr` together with `wrreq`. Expect `empty`=1, `usedw`=0, `almost_empty`=1 (value 2) on the next cycle.
